// File: rtl/slt_share_arbiter.sv
// Round-robin sharing of one set-less-than compare between ALU (port 0) and branch unit (port 1).
// Define SLT_STATS_EN to add saturating grant/contention counters (stat_cnt0, stat_cnt1, stat_contend).
module slt_share_arbiter #(
  parameter int width = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [width-1:0] req0_A,
  input  logic [width-1:0] req0_B,
  input  logic             req0_uns,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [width-1:0] req1_A,
  input  logic [width-1:0] req1_B,
  input  logic             req1_uns,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [width-1:0] resp_Out,
  output logic             busy
`ifdef SLT_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_cnt0,
  output logic [CNT_W-1:0] stat_cnt1,
  output logic [CNT_W-1:0] stat_contend
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  if (width < 2) begin : g_width_chk
    $error("width must be at least 2");
  end
  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("CNT_W must be at least 1");
  end

  logic [1:0]       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic [width-1:0] a_q, a_d;
  logic [width-1:0] b_q, b_d;
  logic             uns_q, uns_d;
  logic [width-1:0] resp_q, resp_d;
  logic             v0_q, v0_d;
  logic             v1_q, v1_d;
  logic             grant0_s, grant1_s;
  logic             accept_s;
  logic             lt_s;

  // Signed less-than uses sign of the difference corrected by overflow; unsigned uses the borrow.
  function automatic logic slt_f(input logic [width-1:0] a, input logic [width-1:0] b,
                                 input logic uns);
    logic [width:0] diff;
    logic           ovf;
    diff = {1'b0, a} - {1'b0, b};
    ovf  = (a[width-1] ^ b[width-1]) & (diff[width-1] ^ a[width-1]);
    if (uns) begin
      return diff[width];
    end else begin
      return diff[width-1] ^ ovf;
    end
  endfunction

  // Arbiter: a lone requester wins; on a tie the pointer picks.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0_s = ~ptr_q;
      grant1_s = ptr_q;
    end else begin
      grant0_s = req0_valid;
      grant1_s = req1_valid;
    end
  end

  assign accept_s   = (state_q == ST_IDLE) && (grant0_s || grant1_s);
  assign req0_ready = reset_n && (state_q == ST_IDLE) && grant0_s;
  assign req1_ready = reset_n && (state_q == ST_IDLE) && grant1_s;
  assign lt_s       = slt_f(a_q, b_q, uns_q);

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    uns_d   = uns_q;
    resp_d  = resp_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          owner_d = grant1_s;
          a_d     = grant1_s ? req1_A : req0_A;
          b_d     = grant1_s ? req1_B : req0_B;
          uns_d   = grant1_s ? req1_uns : req0_uns;
          ptr_d   = ~grant1_s;
          state_d = ST_CMP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMP: begin
        resp_d  = {{(width-1){1'b0}}, lt_s};
        v0_d    = ~owner_q;
        v1_d    = owner_q;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (owner_q ? resp1_ready : resp0_ready) begin
          resp_d  = {width{1'b0}};
          v0_d    = 1'b0;
          v1_d    = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        resp_d  = {width{1'b0}};
        v0_d    = 1'b0;
        v1_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and operand/result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      a_q     <= {width{1'b0}};
      b_q     <= {width{1'b0}};
      uns_q   <= 1'b0;
      resp_q  <= {width{1'b0}};
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      uns_q   <= uns_d;
      resp_q  <= resp_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
    end
  end

  assign resp_Out    = resp_q;
  assign resp0_valid = v0_q;
  assign resp1_valid = v1_q;
  assign busy        = (state_q != ST_IDLE);

`ifdef SLT_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt0_q, cnt1_q, cont_q;

  // Saturating counters: accepts per port and contended grants.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt0_q <= {CNT_W{1'b0}};
      cnt1_q <= {CNT_W{1'b0}};
      cont_q <= {CNT_W{1'b0}};
    end else begin
      if (accept_s && grant0_s && (cnt0_q != CNT_MAX)) begin
        cnt0_q <= cnt0_q + CNT_ONE;
      end
      if (accept_s && grant1_s && (cnt1_q != CNT_MAX)) begin
        cnt1_q <= cnt1_q + CNT_ONE;
      end
      if (accept_s && req0_valid && req1_valid && (cont_q != CNT_MAX)) begin
        cont_q <= cont_q + CNT_ONE;
      end
    end
  end

  assign stat_cnt0    = cnt0_q;
  assign stat_cnt1    = cnt1_q;
  assign stat_contend = cont_q;
`endif

endmodule

// File: tb/tb_slt_share_arbiter.sv
// Directed self-checking bench for slt_share_arbiter (define SLT_STATS_EN to also check counters).
module tb_slt_share_arbiter;
  localparam int W  = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0_valid, req0_ready, req0_uns;
  logic [W-1:0]  req0_A, req0_B;
  logic          req1_valid, req1_ready, req1_uns;
  logic [W-1:0]  req1_A, req1_B;
  logic          resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [W-1:0]  resp_Out;
  logic          busy;
`ifdef SLT_STATS_EN
  logic [CW-1:0] stat_cnt0, stat_cnt1, stat_contend;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  slt_share_arbiter #(.width(W), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B), .req0_uns(req0_uns),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B), .req1_uns(req1_uns),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_Out(resp_Out), .busy(busy)
`ifdef SLT_STATS_EN
    , .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1), .stat_contend(stat_contend)
`endif
  );

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_A = 32'h0; req0_B = 32'h0; req0_uns = 1'b0;
    req1_valid = 1'b0; req1_A = 32'h0; req1_B = 32'h0; req1_uns = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({req0_ready, req1_ready, resp0_valid, resp1_valid, busy} !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected 00000", {req0_ready, req1_ready, resp0_valid, resp1_valid, busy});
    end
    n_vec++;
    if (resp_Out !== 32'h0) begin
      n_err++; $display("FAIL reset_out: got %h expected 00000000", resp_Out);
    end
    reset_n = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_vec++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++; $display("FAIL reset_ptr_tie: got %b expected 10", {req0_ready, req1_ready});
    end
    #1;
    idle_inputs();
  endtask

  task automatic test_compare_port0();
    logic [W-1:0] va [0:6];
    logic [W-1:0] vb [0:6];
    logic         vu [0:6];
    logic [W-1:0] ve [0:6];
    va = '{32'hFFFFFFFB, 32'hFFFFFFFB, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h12345678, 32'h12345678};
    vb = '{32'h00000003, 32'h00000003, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h12345678};
    vu = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    ve = '{32'h1, 32'h0, 32'h1, 32'h0, 32'h1, 32'h0, 32'h0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req0_A = va[i]; req0_B = vb[i]; req0_uns = vu[i]; req0_valid = 1'b1;
      #1;
      n_vec++;
      if (req0_ready !== 1'b1) begin
        n_err++; $display("FAIL cmp%0d_ready: got %b expected 1", i, req0_ready);
      end
      @(negedge clk);
      req0_valid = 1'b0;
      n_vec++;
      if ({req0_ready, busy, resp0_valid} !== 3'b010) begin
        n_err++; $display("FAIL cmp%0d_cmpstate: ready/busy/valid got %b expected 010", i, {req0_ready, busy, resp0_valid});
      end
      @(negedge clk);
      n_vec++;
      if ({resp0_valid, resp1_valid} !== 2'b10) begin
        n_err++; $display("FAIL cmp%0d_valid: got %b expected 10", i, {resp0_valid, resp1_valid});
      end
      n_vec++;
      if (resp_Out !== ve[i]) begin
        n_err++; $display("FAIL cmp%0d_result: got %h expected %h", i, resp_Out, ve[i]);
      end
      resp0_ready = 1'b1;
      @(negedge clk);
      resp0_ready = 1'b0;
      n_vec++;
      if (resp0_valid !== 1'b0 || resp_Out !== 32'h0 || busy !== 1'b0) begin
        n_err++; $display("FAIL cmp%0d_release: valid=%b out=%h busy=%b expected 0/0/0", i, resp0_valid, resp_Out, busy);
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req1_A = 32'hFFFFFFFB; req1_B = 32'h00000003; req1_uns = 1'b0; req1_valid = 1'b1;
    #1;
    n_vec++;
    if (req1_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_req1_ready: got %b expected 1", req1_ready);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    req0_A = 32'h80000000; req0_B = 32'h00000000; req0_uns = 1'b0; req0_valid = 1'b1;
    resp0_ready = 1'b1; resp1_ready = 1'b0;
    #1;
    n_vec++;
    if (req0_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_cmp_req0_ready: got %b expected 0", req0_ready);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++;
      if ({resp1_valid, resp0_valid, req0_ready} !== 3'b100 || resp_Out !== 32'h1) begin
        n_err++;
        $display("FAIL bp_hold%0d: v1/v0/rdy0=%b out=%h expected 100 out=00000001", k, {resp1_valid, resp0_valid, req0_ready}, resp_Out);
      end
    end
    resp1_ready = 1'b1;
    @(negedge clk);
    resp1_ready = 1'b0;
    n_vec++;
    if ({resp1_valid, req0_ready, req1_ready} !== 3'b010 || resp_Out !== 32'h0) begin
      n_err++;
      $display("FAIL bp_release: v1/rdy0/rdy1=%b out=%h expected 010 out=00000000", {resp1_valid, req0_ready, req1_ready}, resp_Out);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (resp0_valid !== 1'b1 || resp_Out !== 32'h1) begin
      n_err++; $display("FAIL bp_port0_result: valid=%b out=%h expected 1 00000001", resp0_valid, resp_Out);
    end
    @(negedge clk);
    resp0_ready = 1'b0;
    n_vec++;
    if (resp0_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL bp_port0_done: valid=%b busy=%b expected 0 0", resp0_valid, busy);
    end
  endtask

  task automatic test_reset_mid_op();
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      req0_A = 32'h80000000; req0_B = 32'h00000001; req0_uns = 1'b0; req0_valid = 1'b1;
      @(negedge clk);
      req0_valid = 1'b0;
      if (p == 1) @(negedge clk);
      reset_n = 1'b0;
      #1;
      n_vec++;
      if ({req0_ready, req1_ready, resp0_valid, resp1_valid, busy} !== 5'b00000 || resp_Out !== 32'h0) begin
        n_err++;
        $display("FAIL rst_mid%0d: ctrl=%b out=%h expected 00000 00000000", p,
                 {req0_ready, req1_ready, resp0_valid, resp1_valid, busy}, resp_Out);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        n_vec++;
        if ({resp0_valid, resp1_valid, busy} !== 3'b000) begin
          n_err++; $display("FAIL rst_stray%0d_%0d: v0/v1/busy=%b expected 000", p, k, {resp0_valid, resp1_valid, busy});
        end
      end
      req0_A = 32'h7FFFFFFF; req0_B = 32'hFFFFFFFF; req0_uns = 1'b1; req0_valid = 1'b1;
      resp0_ready = 1'b1;
      #1;
      n_vec++;
      if (req0_ready !== 1'b1) begin
        n_err++; $display("FAIL rst_next%0d_ready: got %b expected 1", p, req0_ready);
      end
      @(negedge clk);
      req0_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (resp0_valid !== 1'b1 || resp_Out !== 32'h1) begin
        n_err++; $display("FAIL rst_next%0d_result: valid=%b out=%h expected 1 00000001", p, resp0_valid, resp_Out);
      end
      @(negedge clk);
      resp0_ready = 1'b0;
    end
  endtask

  task automatic test_contention();
    logic [W-1:0] a0 [0:3];
    logic [W-1:0] b0 [0:3];
    logic         u0 [0:3];
    logic         e0 [0:3];
    logic [W-1:0] a1 [0:3];
    logic [W-1:0] b1 [0:3];
    logic         u1 [0:3];
    logic         e1 [0:3];
    int   g0 = 0, g1 = 0, cyc = 0, last = 0, nacc = 0, nresp = 0;
    logic exp_owner = 1'b0;
    logic pend_own = 1'b0;
    logic pend_exp = 1'b0;
    logic acc0, acc1;
    a0 = '{32'h5, 32'h7, 32'hFFFFFFFF, 32'h0};
    b0 = '{32'h7, 32'h5, 32'h0, 32'hFFFFFFFF};
    u0 = '{1'b0, 1'b0, 1'b1, 1'b1};
    e0 = '{1'b1, 1'b0, 1'b0, 1'b1};
    a1 = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h3};
    b1 = '{32'h0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3};
    u1 = '{1'b0, 1'b0, 1'b1, 1'b0};
    e1 = '{1'b1, 1'b1, 1'b0, 1'b0};
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    req0_A = a0[0]; req0_B = b0[0]; req0_uns = u0[0]; req0_valid = 1'b1;
    req1_A = a1[0]; req1_B = b1[0]; req1_uns = u1[0]; req1_valid = 1'b1;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    while ((g0 < 4 || g1 < 4 || busy === 1'b1) && cyc < 200) begin
      #1;
      if (resp0_valid === 1'b1 || resp1_valid === 1'b1) begin
        nresp++;
        n_vec++;
        if ({resp1_valid, resp0_valid} !== {pend_own, ~pend_own} || resp_Out !== {31'b0, pend_exp}) begin
          n_err++;
          $display("FAIL cont_resp%0d: v1/v0=%b out=%h expected %b %h", nresp, {resp1_valid, resp0_valid}, resp_Out,
                   {pend_own, ~pend_own}, {31'b0, pend_exp});
        end
      end
      acc0 = (req0_ready === 1'b1) && req0_valid;
      acc1 = (req1_ready === 1'b1) && req1_valid;
      if (acc0 || acc1) begin
        n_vec++;
        if ({acc1, acc0} !== {exp_owner, ~exp_owner}) begin
          n_err++; $display("FAIL cont_grant%0d: got %b expected %b", nacc, {acc1, acc0}, {exp_owner, ~exp_owner});
        end
        if (nacc > 0) begin
          n_vec++;
          if (cyc - last != 3) begin
            n_err++; $display("FAIL cont_interval%0d: got %0d expected 3", nacc, cyc - last);
          end
        end
        last = cyc;
        nacc++;
        exp_owner = ~exp_owner;
        pend_own = acc1;
        pend_exp = acc1 ? e1[g1] : e0[g0];
      end
      @(posedge clk);
      #1;
      if (acc0) begin
        g0++;
        if (g0 < 4) begin
          req0_A = a0[g0]; req0_B = b0[g0]; req0_uns = u0[g0];
        end else begin
          req0_valid = 1'b0;
        end
      end
      if (acc1) begin
        g1++;
        if (g1 < 4) begin
          req1_A = a1[g1]; req1_B = b1[g1]; req1_uns = u1[g1];
        end else begin
          req1_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    n_vec++;
    if (cyc >= 200) begin
      n_err++; $display("FAIL cont_timeout: got %0d cycles expected under 200", cyc);
    end
    n_vec++;
    if (nresp != 8) begin
      n_err++; $display("FAIL cont_resp_count: got %0d expected 8", nresp);
    end
`ifdef SLT_STATS_EN
    n_vec++;
    if (stat_cnt0 !== 16'd4 || stat_cnt1 !== 16'd4 || stat_contend !== 16'd7) begin
      n_err++; $display("FAIL cont_stats: got %0d/%0d/%0d expected 4/4/7", stat_cnt0, stat_cnt1, stat_contend);
    end
`endif
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_compare_port0();
    test_backpressure();
    test_reset_mid_op();
    test_contention();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/slt_share_arbiter.md
Name: slt_share_arbiter

Overview:
- Sequences a single shared set-less-than compare datapath between two requesters: port 0 is the ALU SLT/SLTU path and port 1 is the branch/compare unit.
- Arbitrates requests round-robin and registers operands into the shared compare.
- Holds each width-wide result (0 or 1 in bit 0, upper bits zero) until the owning requester accepts it.
- Sits between the decode/issue stage and the shared less-than compare resources in the MIPS 32-bit datapath.

Parameters:
- width, 32, operand and result width in bits.
- CNT_W, 16, statistics counter width (used only with SLT_STATS_EN).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operand pair.
- req0_ready  output  1  requester 0 request accepted this cycle when high together with req0_valid.
- req0_A  input  width  requester 0 operand A.
- req0_B  input  width  requester 0 operand B.
- req0_uns  input  1  1 = unsigned compare (SLTU), 0 = signed (SLT).
- req1_valid, req1_ready, req1_A, req1_B, req1_uns: same as above, for requester 1.
- resp0_valid  output  1  result for requester 0 is available.
- resp0_ready  input  1  requester 0 consumes the result.
- resp1_valid  output  1  result for requester 1 is available.
- resp1_ready  input  1  requester 1 consumes the result.
- resp_Out  output  width  result; bit 0 = (A < B), bits width-1:1 = 0.
- busy  output  1  high in every state other than IDLE.

Behaviour:
- Reset is asynchronous on reset_n low. All of these go to 0: state=IDLE, req0_ready, req1_ready, resp0_valid, resp1_valid, resp_Out, busy. Round-robin pointer resets to 0 (port 0 wins first tie).
- State IDLE:
  - reqN_ready is high only in IDLE, combinationally, and only for the port chosen by the arbiter.
  - Arbitration: one valid → that port. Both valid → the port indicated by the pointer.
  - On handshake: latch A, B, uns and the owner ID into operand registers, flip the pointer to the non-winner, go to CMP.
- State CMP (1 cycle):
  - The shared compare evaluates the registered operands.
  - Signed: result = (diff[width-1] XOR overflow), where diff = A-B and overflow is the two's-complement subtraction overflow.
  - Unsigned: result = borrow out of A-B.
  - Register result into resp_Out[0], assert resp<owner>_valid, go to RESP.
- State RESP:
  - Hold resp_Out and respN_valid stable until respN_ready is high.
  - On that edge: clear valid, clear resp_Out to 0, go to IDLE.
  - The other port's resp_ready is ignored.
- Latency: request handshake at edge T → resp valid after edge T+1. Minimum issue interval is 3 cycles per compare (accept, CMP, RESP with ready already high).
- Only one compare is in flight at a time. No request is accepted in CMP or RESP; both reqN_ready stay low.
- A requester holding valid must keep its operands stable until its ready is seen. The block does not buffer unaccepted requests.
- Fairness: under continuous requests on both ports, grants alternate 0,1,0,1.
- A reset_n assertion mid-CMP or mid-RESP discards the in-flight result. No resp_valid appears after reset release until a new request is accepted.
- Equal operands → 0. A=most-negative, B=1 (signed) → 1 via the overflow term.

Optional Feature:
- Macro SLT_STATS_EN.
- When defined, adds these outputs, all CNT_W wide, all reset to 0:
  - stat_cnt0, stat_cnt1: incremented on each accepted request of that port.
  - stat_contend: incremented on each IDLE cycle where both valid are high and a grant is made.
- All three counters saturate at all-ones (no wrap).
- When not defined, these ports and registers do not exist. Core behaviour is identical either way.

Test Plan:
- Signed compare, port 0 only: A=0xFFFFFFFB (-5), B=0x00000003, uns=0. → ready in the same cycle; 2 edges later resp0_valid=1 with resp_Out=0x00000001. Repeat with uns=1 → resp_Out=0x00000000.
- Overflow corner: A=0x80000000, B=0x00000001, signed → 1. A=0x7FFFFFFF, B=0xFFFFFFFF, signed → 0; same operands unsigned → 1.
- Contention: both valid continuously, resp ready always high, 4 requests each. → grant order 0,1,0,1,…; each result correct; one accept every 3 cycles. With SLT_STATS_EN: stat_cnt0=4, stat_cnt1=4, stat_contend=7.
- Backpressure: resp1_ready low for 5 cycles after resp1_valid. → resp_Out and resp1_valid stable for all 5 cycles; req0_ready stays 0 throughout; port 0 is granted in the cycle after resp1_ready rises.
- Reset mid-operation: drop reset_n during CMP for one cycle. → all outputs 0 immediately; no stray resp_valid after release; next request completes normally.
- Equal operands: A=B=0x12345678, signed and unsigned → resp_Out=0 both times.
